// File: rtl/chip8_seq_alu_if.sv
// Handshake bundle for the CHIP-8 sequential ALU: operand/op request
// channel (in_*) and result channel (out_*), master drives, slave serves.
interface chip8_seq_alu_if #(
    parameter int WIDTH      = 8,
    parameter int BCD_DIGITS = 3
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic [3:0]              op;
    logic [WIDTH-1:0]        x;
    logic [WIDTH-1:0]        y;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        result;
    logic                    flag;
    logic                    flag_wr;
    logic [4*BCD_DIGITS-1:0] bcd;

    modport master (
        output in_valid, op, x, y, out_ready,
        input  in_ready, out_valid, result, flag, flag_wr, bcd
    );

    modport slave (
        input  in_valid, op, x, y, out_ready,
        output in_ready, out_valid, result, flag, flag_wr, bcd
    );
endinterface

// File: rtl/chip8_seq_alu.sv
// Registered CHIP-8 8xyN ALU with multi-cycle double-dabble BCD (Fx33).
// Ports: clk, rst_n (async active-low), bus (slave: in/out valid-ready).
module chip8_seq_alu #(
    parameter int WIDTH      = 8,
    parameter int BCD_DIGITS = 3,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    chip8_seq_alu_if.slave    bus
);
    localparam int BW = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] result_q;
    logic             flag_q;
    logic             flag_wr_q;
    logic [BW-1:0]    bcd_q;
    logic [WIDTH-1:0] sh_q;
    logic [BW-1:0]    acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic             xfer;
    logic             last;
    logic [WIDTH-1:0] alu_res;
    logic             alu_flag;
    logic             alu_fwr;
    logic [BW-1:0]    adj;
    logic [BW-1:0]    acc_nxt;
    logic [WIDTH-1:0] sh_rot;

    assign xfer = bus.in_valid && (state_q == IDLE);
    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (xfer) state_d = (bus.op == 4'd9) ? BUSY : DONE;
            BUSY: if (last) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Single-cycle ops; the extra bit carries the carry / borrow.
    always_comb begin
        logic [WIDTH:0] sum;
        logic [WIDTH:0] dxy;
        logic [WIDTH:0] dyx;
        sum      = {1'b0, bus.x} + {1'b0, bus.y};
        dxy      = {1'b0, bus.x} - {1'b0, bus.y};
        dyx      = {1'b0, bus.y} - {1'b0, bus.x};
        alu_res  = '0;
        alu_flag = 1'b0;
        alu_fwr  = 1'b0;
        case (bus.op)
            4'd0: alu_res = bus.y;
            4'd1: alu_res = bus.x | bus.y;
            4'd2: alu_res = bus.x & bus.y;
            4'd3: alu_res = bus.x ^ bus.y;
            4'd4: begin
                alu_res  = sum[WIDTH-1:0];
                alu_flag = sum[WIDTH];
                alu_fwr  = 1'b1;
            end
            4'd5: begin
                alu_res  = dxy[WIDTH-1:0];
                alu_flag = ~dxy[WIDTH];
                alu_fwr  = 1'b1;
            end
            4'd6: begin
                alu_res  = {1'b0, bus.x[WIDTH-1:1]};
                alu_flag = bus.x[0];
                alu_fwr  = 1'b1;
            end
            4'd7: begin
                alu_res  = {bus.x[WIDTH-2:0], 1'b0};
                alu_flag = bus.x[WIDTH-1];
                alu_fwr  = 1'b1;
            end
            4'd8: begin
                alu_res  = dyx[WIDTH-1:0];
                alu_flag = ~dyx[WIDTH];
                alu_fwr  = 1'b1;
            end
            default: begin
                alu_res  = '0;
                alu_flag = 1'b0;
                alu_fwr  = 1'b0;
            end
        endcase
    end

    // Double-dabble step: +3 on digits >= 5, then shift in operand MSB.
    // The operand register rotates so it holds x again after WIDTH steps.
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_nxt = {adj[BW-2:0], sh_q[WIDTH-1]};
        sh_rot  = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            flag_q    <= 1'b0;
            flag_wr_q <= 1'b0;
            bcd_q     <= '0;
            sh_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else if (xfer) begin
            if (bus.op == 4'd9) begin
                sh_q  <= bus.x;
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                result_q  <= alu_res;
                flag_q    <= alu_flag;
                flag_wr_q <= alu_fwr;
                bcd_q     <= '0;
            end
        end else if (state_q == BUSY) begin
            acc_q <= acc_nxt;
            sh_q  <= sh_rot;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                result_q  <= sh_rot;
                flag_q    <= 1'b0;
                flag_wr_q <= 1'b0;
                bcd_q     <= acc_nxt;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.flag      = flag_q;
    assign bus.flag_wr   = flag_wr_q;
    assign bus.bcd       = bcd_q;
endmodule

// File: tb/tb_chip8_seq_alu.sv
// Self-checking bench for chip8_seq_alu: directed vector table, random ops
// against an arithmetic reference model, reset and stall sequences.
module tb_chip8_seq_alu;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    chip8_seq_alu_if #(.WIDTH(8), .BCD_DIGITS(3)) bus ();

    chip8_seq_alu #(.WIDTH(8), .BCD_DIGITS(3), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [7:0]  res;
        logic        f;
        logic        fw;
        logic [11:0] bcd;
        int          lat;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model straight from the op table, using integer arithmetic.
    function automatic vec_t model(input int o, input int a, input int b);
        vec_t v;
        v.op = 4'(o); v.x = 8'(a); v.y = 8'(b);
        v.res = 0; v.f = 0; v.fw = 0; v.bcd = 0; v.lat = 1;
        case (o)
            0: v.res = 8'(b);
            1: v.res = 8'(a | b);
            2: v.res = 8'(a & b);
            3: v.res = 8'(a ^ b);
            4: begin
                v.res = 8'((a + b) % 256); v.f = (a + b) > 255; v.fw = 1;
            end
            5: begin
                v.res = 8'((a - b + 256) % 256); v.f = a >= b; v.fw = 1;
            end
            6: begin
                v.res = 8'(a / 2); v.f = (a % 2) == 1; v.fw = 1;
            end
            7: begin
                v.res = 8'((a * 2) % 256); v.f = a >= 128; v.fw = 1;
            end
            8: begin
                v.res = 8'((b - a + 256) % 256); v.f = b >= a; v.fw = 1;
            end
            9: begin
                v.res = 8'(a);
                v.bcd = 12'(((a / 100) * 256) + (((a / 10) % 10) * 16)
                            + (a % 10));
                v.lat = 9;
            end
            default: ;
        endcase
        return v;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int lat;
        logic [7:0] r;
        logic f, fw;
        logic [11:0] bc;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op = v.op; bus.x = v.x; bus.y = v.y;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op = 4'($urandom); bus.x = 8'($urandom); bus.y = 8'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r = bus.result; f = bus.flag; fw = bus.flag_wr; bc = bus.bcd;
        chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
        chk({tag, "_result"}, 32'(r), 32'(v.res));
        chk({tag, "_flag"}, 32'(f), 32'(v.f));
        chk({tag, "_flag_wr"}, 32'(fw), 32'(v.fw));
        chk({tag, "_bcd"}, 32'(bc), 32'(v.bcd));
        chk({tag, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = '0; bus.x = '0; bus.y = '0;

        vt[0]  = '{4'd4, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 12'h000, 1};
        vt[1]  = '{4'd4, 8'h10, 8'h20, 8'h30, 1'b0, 1'b1, 12'h000, 1};
        vt[2]  = '{4'd5, 8'h42, 8'h42, 8'h00, 1'b1, 1'b1, 12'h000, 1};
        vt[3]  = '{4'd5, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b1, 12'h000, 1};
        vt[4]  = '{4'd8, 8'h02, 8'h01, 8'hFF, 1'b0, 1'b1, 12'h000, 1};
        vt[5]  = '{4'd6, 8'h81, 8'h00, 8'h40, 1'b1, 1'b1, 12'h000, 1};
        vt[6]  = '{4'd7, 8'h81, 8'h00, 8'h02, 1'b1, 1'b1, 12'h000, 1};
        vt[7]  = '{4'd7, 8'h7F, 8'h00, 8'hFE, 1'b0, 1'b1, 12'h000, 1};
        vt[8]  = '{4'd9, 8'd255, 8'h00, 8'd255, 1'b0, 1'b0, 12'h255, 9};
        vt[9]  = '{4'd9, 8'd0, 8'h00, 8'd0, 1'b0, 1'b0, 12'h000, 9};
        vt[10] = '{4'd9, 8'd109, 8'h00, 8'd109, 1'b0, 1'b0, 12'h109, 9};
        vt[11] = '{4'd12, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b0, 12'h000, 1};
        vt[12] = '{4'd8, 8'h01, 8'h01, 8'h00, 1'b1, 1'b1, 12'h000, 1};
        vt[13] = '{4'd1, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 12'h000, 1};

        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_flags", 32'({bus.flag, bus.flag_wr}), 32'd0);
        chk("rst_bcd", 32'(bus.bcd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vt[i], $sformatf("vec%0d", i));
        end

        // Abort a BCD conversion with reset partway through.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 4'd9; bus.x = 8'd255;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_outputs", 32'({bus.result, bus.flag, bus.flag_wr}), 32'd0);
        chk("abort_bcd", 32'(bus.bcd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(model(0, 0, 8'h5A), "after_abort");

        // Output stall with an ignored request pulse in the middle.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 4'd3; bus.x = 8'hF0; bus.y = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (c == 2);
            bus.op = 4'd0; bus.x = 8'h11; bus.y = 8'h77;
            chk("stall_result", 32'(bus.result), 32'hCC);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("stall_result_end", 32'(bus.result), 32'hCC);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("stall_release", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("stall_no_ghost", 32'(bus.out_valid), 32'd0);
        chk("stall_hold", 32'(bus.result), 32'hCC);

        for (int i = 0; i < 150; i++) begin
            run_op(model(int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 255))), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
